next_pc_predictor: RTL
======================

Name: next_pc_predictor

Overview:
Fetch-side next-PC generator that sits directly upstream of the program counter register and drives its next-PC input every cycle. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, indexed by the current PC, and predicts either the branch target or PC+4. Resolved branches from EX update the table. On a misprediction the block redirects fetch and asserts a flush request, holding the redirect across fetch stalls.

Parameters:
ENTRIES, 16, number of BTB entries (power of two)
IDX_W, 4, index width = log2(ENTRIES); TAG_W = 30-IDX_W (derived localparam)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
stall_i  in  1  fetch stall, same signal that freezes the PC register
pc_i  in  32  current PC (PC register output)
pred_pc_o  out  32  next PC, drives PC register input
pred_taken_o  out  1  lookup predicted taken; piped down to EX
upd_valid_i  in  1  one-cycle pulse: branch resolved in EX
upd_pc_i  in  32  PC of resolved branch
upd_taken_i  in  1  actual branch outcome
upd_target_i  in  32  actual branch target
upd_pred_pc_i  in  32  next PC that was predicted for this branch
flush_o  out  1  mispredict: squash IF/ID and ID/EX

Behaviour:
- Entry = {valid, tag[TAG_W], target[32], ctr[2]}. index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Reset (rst_i=1 at posedge): all valid=0, all ctr=01, pending redirect cleared.
- Outputs after reset with upd_valid_i=0: flush_o=0, pred_taken_o=0, pred_pc_o=pc_i+4.
- Lookup is combinational, zero latency.
  - hit = valid & tag match.
  - pred_taken_o = hit & ctr[1].
  - pred_pc_o = pred_taken_o ? target : pc_i+4.
  - The +4 is 32-bit, wraps mod 2^32.
- Misprediction detection:
  - actual = upd_taken_i ? upd_target_i : upd_pc_i+4.
  - mispredict = upd_valid_i & (actual != upd_pred_pc_i).
  - When mispredict: flush_o=1 and pred_pc_o=actual in the same cycle. Redirect overrides the lookup and pred_taken_o=0.
- Pending redirect:
  - If mispredict and stall_i=1, latch pend_valid=1, pend_pc=actual.
  - While pend_valid: pred_pc_o=pend_pc and flush_o=1.
  - pend_valid clears at the first posedge with stall_i=0, when the PC loads pend_pc.
  - A new mispredict while pending overwrites pend_pc.
- Table update at posedge when upd_valid_i=1, independent of stall_i:
  - Hit, taken: ctr saturating +1 (11 stays 11); target <= upd_target_i.
  - Hit, not taken: ctr saturating -1 (00 stays 00); target unchanged.
  - Miss, taken: allocate/replace the entry with valid=1, new tag, target=upd_target_i, ctr=10.
  - Miss, not taken: no write.
- Same-cycle lookup and update to the same index: lookup sees the pre-update contents; the write takes effect next cycle.
- Reset mid-operation (pending redirect or update in flight): reset wins. Table invalidated, pending dropped, no write.

Decomposition:
- Shared package holds:
  - IDX_W and TAG_W defaults.
  - Counter encodings SNT/WNT/WT/ST.
  - PC_INC=4.
  - Counter-reset value WNT.
- One sub-module, btb_table: entry storage with one combinational read port (index → entry) and one synchronous write port, plus the valid-bit clear on reset.
- Redirect, pending and counter logic stay in next_pc_predictor.

Test Plan:
- Reset, then pc_i=0x100 -> pred_pc_o=0x104, pred_taken_o=0, flush_o=0.
- Update {pc 0x100, taken, target 0x200, pred_pc 0x104} -> same cycle flush_o=1, pred_pc_o=0x200. Next cycle pc_i=0x100 -> pred_pc_o=0x200, pred_taken_o=1 (ctr=10).
- Two not-taken updates for 0x100:
  - First has pred_pc 0x200 -> flush_o=1, redirect 0x104; ctr 10→01.
  - Second has pred_pc 0x104 -> no flush; ctr→00.
  - Lookup of 0x100 -> 0x104.
- Mispredict {actual 0x300} with stall_i=1 for 3 cycles -> flush_o=1 and pred_pc_o=0x300 in all 3 cycles. After the stall_i=0 cycle, flush_o=0 and the lookup resumes.
- Alias: entry for 0x100 taken→0x200, then lookup 0x140 (same index, different tag) -> miss, 0x144. Taken update for 0x140→0x400 replaces the entry -> 0x100 now misses (0x104), 0x140 predicts 0x400.
- pc_i=0xFFFFFFFC miss -> pred_pc_o=0x00000000. Assert rst_i while pend_valid=1 -> next cycle flush_o=0, all lookups miss.

Source files
------------

// File: rtl/next_pc_predictor_pkg.sv
// Shared constants for the fetch next-PC predictor: BTB geometry defaults,
// 2-bit counter encodings and the sequential PC step.
package next_pc_predictor_pkg;

  localparam int IDX_W_DEF = 4;
  localparam int TAG_W_DEF = 30 - IDX_W_DEF;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam logic [31:0] PC_INC  = 32'd4;
  localparam ctr_e        CTR_RST = CTR_WNT;

endpackage

// File: rtl/next_pc_predictor_btb_table.sv
// Direct-mapped BTB storage: combinational reads, one synchronous write port.
// Read latency 0 cycles; write visible the cycle after the edge.
// No backpressure; reset clears valid bits and re-arms counters to weakly-not-taken.
module btb_table
  import next_pc_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_target,
  output logic [1:0]       rd_ctr,
  input  logic [IDX_W-1:0] up_idx,
  output logic             up_valid,
  output logic [TAG_W-1:0] up_tag,
  output logic [31:0]      up_target,
  output logic [1:0]       up_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  logic [1:0]       wr_ctr
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  // Fetch lookup port and the EX-update read-modify-write port.
  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];

  assign up_valid  = valid_q[up_idx];
  assign up_tag    = tag_q[up_idx];
  assign up_target = target_q[up_idx];
  assign up_ctr    = ctr_q[up_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch next-PC generator: BTB prediction, mispredict redirect and flush request.
// Lookup and redirect are combinational (0 cycles); table writes land next cycle.
// A redirect raised under stall_i is held until the first unstalled edge.
module next_pc_predictor
  import next_pc_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pred_pc_o,
  output logic        pred_taken_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic [31:0] upd_pred_pc_i,
  output logic        flush_o
);

  localparam int TAG_W = 30 - IDX_W;

  logic             lk_valid, up_valid;
  logic [TAG_W-1:0] lk_tag, up_tag, wr_tag;
  logic [31:0]      lk_target, up_target, wr_target;
  logic [1:0]       lk_ctr, up_ctr, wr_ctr;
  logic             wr_en, up_hit, lk_hit;
  logic [31:0]      actual_pc, seq_pc;
  logic             mispredict;
  logic             pend_valid;
  logic [31:0]      pend_pc;

  btb_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_idx    (pc_i[IDX_W+1:2]),
    .rd_valid  (lk_valid),
    .rd_tag    (lk_tag),
    .rd_target (lk_target),
    .rd_ctr    (lk_ctr),
    .up_idx    (upd_pc_i[IDX_W+1:2]),
    .up_valid  (up_valid),
    .up_tag    (up_tag),
    .up_target (up_target),
    .up_ctr    (up_ctr),
    .wr_en     (wr_en),
    .wr_idx    (upd_pc_i[IDX_W+1:2]),
    .wr_tag    (wr_tag),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  assign seq_pc     = pc_i + PC_INC;
  assign actual_pc  = upd_taken_i ? upd_target_i : upd_pc_i + PC_INC;
  assign mispredict = upd_valid_i && (actual_pc != upd_pred_pc_i);
  assign lk_hit     = lk_valid && (lk_tag == pc_i[31:IDX_W+2]);
  assign up_hit     = up_valid && (up_tag == upd_pc_i[31:IDX_W+2]);

  // Not-taken misses leave the table alone so cold code never pollutes it.
  always_comb begin
    wr_en     = upd_valid_i && (up_hit || upd_taken_i);
    wr_tag    = upd_pc_i[31:IDX_W+2];
    wr_target = (up_hit && !upd_taken_i) ? up_target : upd_target_i;
    wr_ctr    = CTR_WT;
    if (up_hit) begin
      if (upd_taken_i) wr_ctr = (up_ctr == CTR_ST)  ? CTR_ST  : up_ctr + 2'd1;
      else             wr_ctr = (up_ctr == CTR_SNT) ? CTR_SNT : up_ctr - 2'd1;
    end
  end

  // A fresh mispredict outranks an older held redirect.
  always_comb begin
    pred_pc_o    = seq_pc;
    pred_taken_o = 1'b0;
    flush_o      = 1'b0;
    if (mispredict) begin
      pred_pc_o = actual_pc;
      flush_o   = 1'b1;
    end else if (pend_valid) begin
      pred_pc_o = pend_pc;
      flush_o   = 1'b1;
    end else if (lk_hit && lk_ctr[1]) begin
      pred_pc_o    = lk_target;
      pred_taken_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid <= 1'b0;
    end else if (mispredict && stall_i) begin
      pend_valid <= 1'b1;
      pend_pc    <= actual_pc;
    end else if (!stall_i) begin
      pend_valid <= 1'b0;
    end
  end

endmodule
